sdram_rw_sched: RTL and testbench

Single-clock scheduler that shares one SDRAM burst controller between two requesters. The write side is a frame-generator FIFO; the read side is a VGA prefetch FIFO.
- Decides which side gets each burst and tracks per-frame write/read addresses.
- Sizes each burst and handles frame wrap.
- Issues valid/ready burst commands to the controller.
- Paces the frame generator with a new-frame request.
Sits in the SDRAM clock domain, between the CDC FIFOs and the SDRAM controller.

---
 rtl/sdram_sched_pkg.sv | 15 +
 rtl/sdram_sched_ptr.sv | 47 ++++
 rtl/sdram_rw_sched.sv | 177 +++++++++++++++++
 tb/tb_sdram_rw_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared constants for the SDRAM read/write burst scheduler:
// FSM state encoding and command direction values.
package sdram_sched_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_WAIT_INIT = 2'd0;
   localparam state_t ST_ARB       = 2'd1;
   localparam state_t ST_ISSUE     = 2'd2;
   localparam state_t ST_WAIT_DONE = 2'd3;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/sdram_sched_ptr.sv
// Per-side frame pointer: computes the next burst length (clipped at the frame
// end) and advances or restarts the word pointer, flagging a frame wrap.
module sdram_sched_ptr #(
   parameter int DATA_DEPTH = 1024*240,
   parameter int BURST_LEN  = 256,
   parameter int ADDR_W     = 24,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              restart,
   input  logic [CNT_W-1:0]  adv_len,
   output logic [ADDR_W-1:0] ptr,
   output logic [CNT_W-1:0]  len,
   output logic              wrap
);

   localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(DATA_DEPTH);
   localparam logic [ADDR_W-1:0] BLEN  = ADDR_W'(BURST_LEN);

   logic [ADDR_W-1:0] remain;
   logic [ADDR_W-1:0] ptr_next;

   // A pointer sitting exactly at the frame end is treated as a fresh frame.
   always_comb begin
      remain   = DEPTH - ptr;
      ptr_next = ptr + ADDR_W'(adv_len);
      if (remain == '0 || remain >= BLEN) begin
         len = CNT_W'(BURST_LEN);
      end else begin
         len = remain[CNT_W-1:0];
      end
      wrap = advance && !restart && (ptr_next >= DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (restart) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (ptr_next >= DEPTH) ? '0 : ptr_next;
      end
   end

endmodule

// File: rtl/sdram_rw_sched.sv
// Arbitrates one SDRAM burst controller between the frame-generator write FIFO
// and the VGA read FIFO. Define SDRAM_SCHED_DOUBLE_BUF_EN for front/back buffers.
module sdram_rw_sched #(
   parameter int DATA_DEPTH    = 1024*240,
   parameter int BURST_LEN     = 256,
   parameter int ADDR_W        = 24,
   parameter int CNT_W         = 10,
   parameter int MAX_RD_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   input  logic [CNT_W-1:0]  wr_fifo_cnt,
   input  logic [CNT_W-1:0]  rd_fifo_free,
   input  logic              rd_frame_start,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [CNT_W-1:0]  cmd_len,
   input  logic              cmd_done,
   output logic              new_frame_req,
   output logic              wr_frame_done,
   output logic              busy
);

   import sdram_sched_pkg::*;

   localparam int SW = $clog2(MAX_RD_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

   state_t            state;
   logic              wr_active;
   logic              rd_restart_pend;
   logic [SW-1:0]     rd_streak;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_base, rd_base;
   logic [CNT_W-1:0]  wlen, rlen;
   logic              wr_adv, rd_done, rd_outstanding, rd_restart;
   logic              wr_wrap, rd_wrap_unused;
   logic              wr_elig, rd_elig, grant_wr, grant_rd, start_frame;

   always_comb begin
      wr_adv         = (state == ST_WAIT_DONE) && cmd_done && (cmd_wr == CMD_WR);
      rd_done        = (state == ST_WAIT_DONE) && cmd_done && (cmd_wr == CMD_RD);
      rd_outstanding = ((state == ST_ISSUE) || (state == ST_WAIT_DONE)) && (cmd_wr == CMD_RD);
      rd_restart     = (rd_frame_start && !rd_outstanding) ||
                       (rd_done && (rd_restart_pend || rd_frame_start));
      wr_elig        = wr_active && (wr_fifo_cnt >= wlen);
      rd_elig        = rd_fifo_free >= rlen;
      grant_wr       = wr_elig && (!rd_elig || (rd_streak == STREAK_MAX));
      grant_rd       = rd_elig && !grant_wr;
      start_frame    = rd_frame_start && !wr_active && (state != ST_WAIT_INIT);
   end

   sdram_sched_ptr #(
      .DATA_DEPTH (DATA_DEPTH),
      .BURST_LEN  (BURST_LEN),
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W)
   ) u_wr_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (wr_adv),
      .restart (1'b0),
      .adv_len (cmd_len),
      .ptr     (wr_ptr),
      .len     (wlen),
      .wrap    (wr_wrap)
   );

   sdram_sched_ptr #(
      .DATA_DEPTH (DATA_DEPTH),
      .BURST_LEN  (BURST_LEN),
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W)
   ) u_rd_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (rd_done),
      .restart (rd_restart),
      .adv_len (cmd_len),
      .ptr     (rd_ptr),
      .len     (rlen),
      .wrap    (rd_wrap_unused)
   );

`ifdef SDRAM_SCHED_DOUBLE_BUF_EN
   localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(DATA_DEPTH);
   logic front_sel;

   // The display buffer flips only once the back buffer holds a complete frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         front_sel <= 1'b0;
      end else if (start_frame) begin
         front_sel <= ~front_sel;
      end
   end

   assign rd_base = front_sel ? DEPTH : '0;
   assign wr_base = front_sel ? '0 : DEPTH;
`else
   assign rd_base = '0;
   assign wr_base = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_WAIT_INIT;
         cmd_valid       <= 1'b0;
         cmd_wr          <= CMD_RD;
         cmd_addr        <= '0;
         cmd_len         <= '0;
         new_frame_req   <= 1'b0;
         wr_frame_done   <= 1'b0;
         busy            <= 1'b0;
         wr_active       <= 1'b0;
         rd_streak       <= '0;
         rd_restart_pend <= 1'b0;
      end else begin
         new_frame_req <= 1'b0;
         wr_frame_done <= wr_wrap;
         if (wr_wrap) begin
            wr_active <= 1'b0;
         end
         if (start_frame) begin
            new_frame_req <= 1'b1;
            wr_active     <= 1'b1;
         end
         if (rd_done) begin
            rd_restart_pend <= 1'b0;
         end else if (rd_frame_start && rd_outstanding) begin
            rd_restart_pend <= 1'b1;
         end

         case (state)
            ST_WAIT_INIT: begin
               if (init_done) begin
                  new_frame_req <= 1'b1;
                  wr_active     <= 1'b1;
                  state         <= ST_ARB;
               end
            end
            // No grant while a read restart lands, so the read address is never stale.
            ST_ARB: begin
               if (!rd_frame_start && (grant_wr || grant_rd)) begin
                  cmd_valid <= 1'b1;
                  busy      <= 1'b1;
                  cmd_wr    <= grant_wr ? CMD_WR : CMD_RD;
                  cmd_addr  <= grant_wr ? (wr_base + wr_ptr) : (rd_base + rd_ptr);
                  cmd_len   <= grant_wr ? wlen : rlen;
                  if (grant_wr) begin
                     rd_streak <= '0;
                  end else if (rd_streak != STREAK_MAX) begin
                     rd_streak <= rd_streak + 1'b1;
                  end
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (cmd_done) begin
                  busy  <= 1'b0;
                  state <= ST_ARB;
               end
            end
            default: state <= ST_WAIT_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_rw_sched.sv
// Directed bench for sdram_rw_sched with a small frame (600 words) so that
// bursts clip at the frame end; bench tracks buffer bases for both build modes.
module tb_sdram_rw_sched;

   localparam int DD  = 600;
   localparam int BL  = 256;
   localparam int AW  = 12;
   localparam int CW  = 10;
   localparam int MRS = 4;

   logic          clk = 1'b0;
   logic          rst, init_done, rd_frame_start, cmd_ready, cmd_done;
   logic [CW-1:0] wr_fifo_cnt, rd_fifo_free;
   logic          cmd_valid, cmd_wr, new_frame_req, wr_frame_done, busy;
   logic [AW-1:0] cmd_addr;
   logic [CW-1:0] cmd_len;

   int errors = 0;
   int checks = 0;
   int fd_pulses = 0;
   logic [AW-1:0] rd_base, wr_base;

   sdram_rw_sched #(
      .DATA_DEPTH    (DD),
      .BURST_LEN     (BL),
      .ADDR_W        (AW),
      .CNT_W         (CW),
      .MAX_RD_STREAK (MRS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .init_done      (init_done),
      .wr_fifo_cnt    (wr_fifo_cnt),
      .rd_fifo_free   (rd_fifo_free),
      .rd_frame_start (rd_frame_start),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_wr         (cmd_wr),
      .cmd_addr       (cmd_addr),
      .cmd_len        (cmd_len),
      .cmd_done       (cmd_done),
      .new_frame_req  (new_frame_req),
      .wr_frame_done  (wr_frame_done),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_frame_done === 1'b1) fd_pulses++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Plays the controller: waits for a command, accepts it, then completes it.
   // rs=1 pulses rd_frame_start mid-burst, rs=2 pulses it together with cmd_done.
   task automatic serve(input int rs, output bit got, output logic w,
                        output logic [AW-1:0] a, output logic [CW-1:0] l);
      got = 1'b0; w = 1'b0; a = '0; l = '0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) got = 1'b1;
      end
      if (got) begin
         w = cmd_wr; a = cmd_addr; l = cmd_len;
         cmd_ready = 1'b1;
         @(negedge clk);
         cmd_ready = 1'b0;
         if (rs == 1) begin
            rd_frame_start = 1'b1;
            @(negedge clk);
            rd_frame_start = 1'b0;
         end
         cmd_done = 1'b1;
         if (rs == 2) rd_frame_start = 1'b1;
         @(negedge clk);
         cmd_done = 1'b0;
         rd_frame_start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; init_done = 1'b0; rd_frame_start = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0;
      wr_fifo_cnt = 10'd256; rd_fifo_free = 10'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_wr, cmd_addr, cmd_len, new_frame_req, wr_frame_done, busy} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: valid=%b wr=%b addr=%0d len=%0d nfr=%b wfd=%b busy=%b, want all 0",
                  cmd_valid, cmd_wr, cmd_addr, cmd_len, new_frame_req, wr_frame_done, busy);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b0 || new_frame_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_init_idle: valid=%b nfr=%b, want 0 0", cmd_valid, new_frame_req);
      end
   endtask

   task automatic test_first_write();
      bit got; logic w; logic [AW-1:0] a; logic [CW-1:0] l;
      init_done = 1'b1;
      @(negedge clk);
      checks++;
      if (new_frame_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL init_new_frame: nfr=%b want 1", new_frame_req);
      end
      for (int k = 0; k < 2; k++) begin
         serve(0, got, w, a, l);
         checks++;
         if (!got || w !== 1'b1 || a !== wr_base + AW'(k * 256) || l !== 10'd256) begin
            errors++;
            $display("[TB] FAIL first_write%0d: got=%b wr=%b addr=%0d len=%0d, want wr=1 addr=%0d len=256",
                     k, got, w, a, l, wr_base + AW'(k * 256));
         end
      end
   endtask

   task automatic test_frame_wrap();
      bit got; logic w; logic [AW-1:0] a; logic [CW-1:0] l;
      int fd0;
      bit idle;
      fd0 = fd_pulses;
      serve(0, got, w, a, l);
      checks++;
      if (!got || w !== 1'b1 || a !== wr_base + AW'(512) || l !== 10'd88) begin
         errors++;
         $display("[TB] FAIL tail_write: got=%b wr=%b addr=%0d len=%0d, want wr=1 addr=%0d len=88",
                  got, w, a, l, wr_base + AW'(512));
      end
      idle = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (cmd_valid !== 1'b0) idle = 1'b0;
      end
      checks++;
      if (!idle) begin
         errors++;
         $display("[TB] FAIL idle_after_frame: cmd_valid seen=1, want 0");
      end
      checks++;
      if (fd_pulses - fd0 != 1) begin
         errors++;
         $display("[TB] FAIL frame_done_count: pulses=%0d want 1", fd_pulses - fd0);
      end
   endtask

   task automatic test_rd_streak();
      bit got; logic w; logic [AW-1:0] a; logic [CW-1:0] l;
      logic          exp_w [10];
      logic [AW-1:0] exp_a [10];
      logic [CW-1:0] exp_l [10];
      rd_frame_start = 1'b1;
      @(negedge clk);
      rd_frame_start = 1'b0;
      checks++;
      if (new_frame_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL streak_new_frame: nfr=%b want 1", new_frame_req);
      end
`ifdef SDRAM_SCHED_DOUBLE_BUF_EN
      rd_base = AW'(DD); wr_base = '0;
`endif
      rd_fifo_free = 10'd256;
      exp_w = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      exp_a = '{rd_base, rd_base + AW'(256), rd_base + AW'(512), rd_base,
                wr_base, rd_base + AW'(256), rd_base + AW'(512), rd_base,
                rd_base + AW'(256), wr_base + AW'(256)};
      exp_l = '{10'd256, 10'd256, 10'd88, 10'd256, 10'd256,
                10'd256, 10'd88, 10'd256, 10'd256, 10'd256};
      for (int k = 0; k < 10; k++) begin
         serve(0, got, w, a, l);
         checks++;
         if (!got || w !== exp_w[k] || a !== exp_a[k] || l !== exp_l[k]) begin
            errors++;
            $display("[TB] FAIL streak_grant%0d: got=%b wr=%b addr=%0d len=%0d, want wr=%b addr=%0d len=%0d",
                     k, got, w, a, l, exp_w[k], exp_a[k], exp_l[k]);
         end
      end
   endtask

   task automatic test_rd_restart();
      bit got; logic w; logic [AW-1:0] a; logic [CW-1:0] l;
      int            rs    [6];
      logic [AW-1:0] exp_a [6];
      logic [CW-1:0] exp_l [6];
      wr_fifo_cnt = 10'd0;
      rs    = '{0, 0, 1, 0, 2, 0};
      exp_a = '{rd_base + AW'(512), rd_base, rd_base + AW'(256), rd_base,
                rd_base + AW'(256), rd_base};
      exp_l = '{10'd88, 10'd256, 10'd256, 10'd256, 10'd256, 10'd256};
      for (int k = 0; k < 6; k++) begin
         serve(rs[k], got, w, a, l);
         checks++;
         if (!got || w !== 1'b0 || a !== exp_a[k] || l !== exp_l[k]) begin
            errors++;
            $display("[TB] FAIL restart_read%0d: got=%b wr=%b addr=%0d len=%0d, want wr=0 addr=%0d len=%0d",
                     k, got, w, a, l, exp_a[k], exp_l[k]);
         end
      end
   endtask

   task automatic test_issue_stall();
      bit got, stable;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL stall_cmd_seen: no cmd_valid within 40 cycles");
      end
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if ({cmd_valid, cmd_wr, cmd_addr, cmd_len, busy} !==
             {1'b1, 1'b0, rd_base + AW'(256), 10'd256, 1'b1}) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("[TB] FAIL stall_hold: valid=%b wr=%b addr=%0d len=%0d busy=%b, want 1 0 %0d 256 1",
                  cmd_valid, cmd_wr, cmd_addr, cmd_len, busy, rd_base + AW'(256));
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      checks++;
      if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_handshake: valid=%b busy=%b, want 0 1", cmd_valid, busy);
      end
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_done_busy: busy=%b want 0", busy);
      end
   endtask

   task automatic test_new_frame();
      bit got; logic w; logic [AW-1:0] a; logic [CW-1:0] l;
      int fd0;
      rd_fifo_free = 10'd0;
      wr_fifo_cnt  = 10'd256;
      fd0 = fd_pulses;
      serve(0, got, w, a, l);
      checks++;
      if (!got || w !== 1'b1 || a !== wr_base + AW'(512) || l !== 10'd88) begin
         errors++;
         $display("[TB] FAIL nf_last_write: got=%b wr=%b addr=%0d len=%0d, want wr=1 addr=%0d len=88",
                  got, w, a, l, wr_base + AW'(512));
      end
      repeat (2) @(negedge clk);
      checks++;
      if (fd_pulses - fd0 != 1) begin
         errors++;
         $display("[TB] FAIL nf_frame_done: pulses=%0d want 1", fd_pulses - fd0);
      end
      rd_frame_start = 1'b1;
      @(negedge clk);
      rd_frame_start = 1'b0;
      checks++;
      if (new_frame_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL nf_request: nfr=%b want 1", new_frame_req);
      end
`ifdef SDRAM_SCHED_DOUBLE_BUF_EN
      rd_base = '0; wr_base = AW'(DD);
`endif
      wr_fifo_cnt  = 10'd0;
      rd_fifo_free = 10'd256;
      serve(0, got, w, a, l);
      checks++;
      if (!got || w !== 1'b0 || a !== rd_base || l !== 10'd256) begin
         errors++;
         $display("[TB] FAIL nf_first_read: got=%b wr=%b addr=%0d len=%0d, want wr=0 addr=%0d len=256",
                  got, w, a, l, rd_base);
      end
      rd_fifo_free = 10'd0;
      wr_fifo_cnt  = 10'd256;
      serve(0, got, w, a, l);
      checks++;
      if (!got || w !== 1'b1 || a !== wr_base || l !== 10'd256) begin
         errors++;
         $display("[TB] FAIL nf_first_write: got=%b wr=%b addr=%0d len=%0d, want wr=1 addr=%0d len=256",
                  got, w, a, l, wr_base);
      end
   endtask

   initial begin
      rd_base = '0;
`ifdef SDRAM_SCHED_DOUBLE_BUF_EN
      wr_base = AW'(DD);
`else
      wr_base = '0;
`endif
      $display("[TB] sdram_rw_sched directed test start");
      test_reset();
      test_first_write();
      test_frame_wrap();
      test_rd_streak();
      test_rd_restart();
      test_issue_stall();
      test_new_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
